// File: rtl/hc595_frame_monitor_if.sv
// hc595_frame_monitor_if: 74HC595 link lines plus decoded frame/digit results
interface hc595_frame_monitor_if;
  logic SCLK, RCLK, DIO;
  logic [15:0] frame;
  logic frame_valid;
  logic [3:0] d0, d1, d2, d3, digit_known;
  logic frame_err, sel_err, seg_err;
  modport master (
    output SCLK, RCLK, DIO,
    input frame, frame_valid, d0, d1, d2, d3, digit_known, frame_err, sel_err, seg_err
  );
  modport slave (
    input SCLK, RCLK, DIO,
    output frame, frame_valid, d0, d1, d2, d3, digit_known, frame_err, sel_err, seg_err
  );
endinterface

// File: rtl/hc595_frame_monitor.sv
// hc595_frame_monitor: samples a 74HC595 link, rebuilds frames and tracks the 4-digit hex image
module hc595_frame_monitor #(
  parameter int WIDTH = 16,
  parameter int SYNC_STAGES = 2,
  parameter int IDLE_TO = 4096
) (
  input logic clk,
  input logic rst,
  hc595_frame_monitor_if.slave bus
);
  localparam int IW = $clog2(IDLE_TO + 1);
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [SYNC_STAGES-1:0] s_sync, r_sync, d_sync;
  logic s_prev, r_prev, s_rise, r_rise, sel_ok, hit;
  logic [15:0] shift_reg, frame;
  logic [4:0] bit_cnt;
  logic [IW-1:0] idle_cnt;
  logic [3:0] dig [4];
  logic [3:0] known, val;
  logic [1:0] idx;
  logic frame_valid, frame_err, sel_err, seg_err;
  assign s_rise = s_sync[SYNC_STAGES-1] & ~s_prev;
  assign r_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign sel_ok = $onehot(~frame[3:0]) && frame[7:4] == 4'hF;
  always_comb begin
    val = '0;
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < 16; i++)
      if (~frame[14:8] == HEX[i]) begin
        val = 4'(i);
        hit = 1'b1;
      end
    for (int i = 0; i < 4; i++)
      if (!frame[i]) idx = 2'(i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s_sync <= '0;
      r_sync <= '0;
      d_sync <= '0;
      s_prev <= 1'b0;
      r_prev <= 1'b0;
      shift_reg <= '0;
      bit_cnt <= '0;
      idle_cnt <= '0;
      frame <= '0;
      frame_valid <= 1'b0;
      frame_err <= 1'b0;
      sel_err <= 1'b0;
      seg_err <= 1'b0;
      known <= '0;
      dig <= '{default: '0};
    end else begin
      s_sync <= {s_sync[SYNC_STAGES-2:0], bus.SCLK};
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.RCLK};
      d_sync <= {d_sync[SYNC_STAGES-2:0], bus.DIO};
      s_prev <= s_sync[SYNC_STAGES-1];
      r_prev <= r_sync[SYNC_STAGES-1];
      frame_valid <= r_rise;
      frame_err <= r_rise && bit_cnt != 5'(WIDTH);
      sel_err <= frame_valid && !sel_ok;
      seg_err <= frame_valid && sel_ok && !hit;
      idle_cnt <= (s_rise || r_rise) ? '0 : idle_cnt + IW'(idle_cnt != IW'(IDLE_TO));
      // latch sees the pre-shift register when both edges land together
      if (r_rise) frame <= shift_reg;
      if (s_rise) shift_reg <= {shift_reg[14:0], d_sync[SYNC_STAGES-1]};
      if (r_rise) bit_cnt <= {4'b0, s_rise};
      else if (s_rise) bit_cnt <= bit_cnt + 5'(bit_cnt != 5'd31);
      else if (idle_cnt == IW'(IDLE_TO) && bit_cnt != '0) begin
        bit_cnt <= '0;
        shift_reg <= '0;
      end
      if (frame_valid && sel_ok) begin
        known[idx] <= hit;
        if (hit) dig[idx] <= val;
      end
    end
  end
  assign bus.frame = frame;
  assign bus.frame_valid = frame_valid;
  assign bus.frame_err = frame_err;
  assign bus.sel_err = sel_err;
  assign bus.seg_err = seg_err;
  assign bus.digit_known = known;
  assign bus.d0 = dig[0];
  assign bus.d1 = dig[1];
  assign bus.d2 = dig[2];
  assign bus.d3 = dig[3];
endmodule
